servo_pwm_gen: RTL and testbench

Servo PWM generator that takes the 20-bit duty word produced by the angle-to-duty converter and drives one hobby-servo control line. It produces a fixed 20 ms frame (1_000_000 cycles at 50 MHz) with a high pulse of `duty` cycles. Duty updates take effect only at frame boundaries, and each change is clamped to the legal servo range and optionally slew-limited. One instance sits per servo channel, directly downstream of the converter.

---
 rtl/servo_pwm_gen.sv | 143 ++++++++++++++
 tb/tb_servo_pwm_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen
//   Hobby-servo PWM generator. Produces a fixed frame of PERIOD clock cycles
//   whose leading pulse lasts duty_applied cycles. The requested duty word is
//   sampled only at frame boundaries, clamped to [DUTY_MIN, DUTY_MAX] and,
//   while running, slew-limited to at most STEP cycles of change per frame.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst          : asynchronous active-high reset
//   en           : run request (level); dropping it lets the current frame finish
//   duty[19:0]   : requested pulse width in cycles (unsigned)
//   pwm_out      : registered servo control line
//   period_tick  : registered one-cycle strobe in the first cycle of each frame
//   duty_applied : pulse width used for the current frame
//   active       : high while a frame is running (RUN or STOP)
module servo_pwm_gen #(
    parameter int unsigned PERIOD   = 1_000_000,
    parameter int unsigned DUTY_MIN = 25_000,
    parameter int unsigned DUTY_MAX = 125_000,
    parameter int unsigned STEP     = 1_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [19:0] duty,
    output logic        pwm_out,
    output logic        period_tick,
    output logic [19:0] duty_applied,
    output logic        active
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    localparam logic [19:0]        CNT_LAST = 20'(PERIOD - 1);
    localparam logic [19:0]        MIN_W    = 20'(DUTY_MIN);
    localparam logic [19:0]        MAX_W    = 20'(DUTY_MAX);
    localparam logic [19:0]        STEP_W   = 20'(STEP);
    localparam logic signed [20:0] STEP_S   = 21'(STEP);
    localparam logic [19:0]        RST_DUTY = 20'((DUTY_MIN + DUTY_MAX) / 2);

    // Saturate the requested width into the legal servo range.
    function automatic logic [19:0] f_clamp(input logic [19:0] d);
        if (d < MIN_W)
            return MIN_W;
        else if (d > MAX_W)
            return MAX_W;
        else
            return d;
    endfunction

    // Move cur toward tgt by at most STEP. Both operands already lie inside
    // the clamp window, so a partial step can never leave it.
    function automatic logic [19:0] f_slew(input logic [19:0] cur, input logic [19:0] tgt);
        logic signed [20:0] diff;
        diff = signed'({1'b0, tgt}) - signed'({1'b0, cur});
        if (STEP == 0 || (diff <= STEP_S && diff >= -STEP_S))
            return tgt;
        else if (diff > 0)
            return cur + STEP_W;
        else
            return cur - STEP_W;
    endfunction

    logic [1:0]  r_state;
    logic [19:0] r_cnt;
    logic [19:0] r_duty;
    logic        r_pwm;
    logic        r_tick;

    logic [19:0] w_tgt;
    logic        w_wrap;
    logic [1:0]  w_state_nxt;
    logic [19:0] w_cnt_nxt;
    logic [19:0] w_duty_nxt;
    logic        w_tick_nxt;
    logic        w_pwm_nxt;

    assign w_tgt  = f_clamp(duty);
    assign w_wrap = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_duty_nxt  = r_duty;
        w_tick_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    // Start: first frame uses the clamped target directly.
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 20'd0;
                    w_duty_nxt  = w_tgt;
                    w_tick_nxt  = 1'b1;
                end
            end
            default: begin
                if (w_wrap) begin
                    w_cnt_nxt = 20'd0;
                    // A STOP that sees en again at the wrap behaves exactly
                    // like an uninterrupted RUN, so en toggles within a frame
                    // are invisible on the outputs.
                    if (r_state == S_RUN || en) begin
                        w_duty_nxt  = f_slew(r_duty, w_tgt);
                        w_tick_nxt  = 1'b1;
                        w_state_nxt = en ? S_RUN : S_STOP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + 20'd1;
                    w_state_nxt = en ? S_RUN : S_STOP;
                end
            end
        endcase
        // The output register is computed from the next counter/duty so that
        // pwm_out lines up with cnt in the same cycle.
        w_pwm_nxt = (w_state_nxt != S_IDLE) && (w_cnt_nxt < w_duty_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 20'd0;
            r_duty  <= RST_DUTY;
            r_pwm   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_duty  <= w_duty_nxt;
            r_pwm   <= w_pwm_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    assign pwm_out      = r_pwm;
    assign period_tick  = r_tick;
    assign duty_applied = r_duty;
    assign active       = (r_state != S_IDLE);

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen. Instance 0 runs scaled-down frames (PERIOD 1000,
// clamp 25..125, STEP 2) under directed stimulus with literal expectations;
// instances 1 and 2 (PERIOD 100, clamp 10..90, STEP 5 and STEP 0) share a
// random duty/en stream. A frame-level model checks all three every cycle.
module tb_servo_pwm_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0;
    logic        en_r = 1'b0;
    logic [19:0] duty_a = 20'd75;
    logic [19:0] duty_r = 20'd50;
    logic [2:0]  pwm_o, tick_o, act_o;
    logic [19:0] app_o [3];
    bit          rnd_done = 1'b0;

    int tests = 0;
    int fails = 0;
    int shown = 0;

    always #5 clk = ~clk;

    servo_pwm_gen #(.PERIOD(1000), .DUTY_MIN(25), .DUTY_MAX(125), .STEP(2)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .duty(duty_a),
        .pwm_out(pwm_o[0]), .period_tick(tick_o[0]), .duty_applied(app_o[0]), .active(act_o[0]));
    servo_pwm_gen #(.PERIOD(100), .DUTY_MIN(10), .DUTY_MAX(90), .STEP(5)) u_b (
        .clk(clk), .rst(rst), .en(en_r), .duty(duty_r),
        .pwm_out(pwm_o[1]), .period_tick(tick_o[1]), .duty_applied(app_o[1]), .active(act_o[1]));
    servo_pwm_gen #(.PERIOD(100), .DUTY_MIN(10), .DUTY_MAX(90), .STEP(0)) u_c (
        .clk(clk), .rst(rst), .en(en_r), .duty(duty_r),
        .pwm_out(pwm_o[2]), .period_tick(tick_o[2]), .duty_applied(app_o[2]), .active(act_o[2]));

    // ---------------- frame-level model ----------------
    int P  [3] = '{1000, 100, 100};
    int MN [3] = '{25, 10, 10};
    int MX [3] = '{125, 90, 90};
    int ST [3] = '{2, 5, 0};

    int m_mode [3];   // 0 idle, 1 running, 2 finishing last frame
    int m_pos  [3];   // position inside the current frame
    int m_app  [3];

    function automatic bit en_of(int i);
        return (i == 0) ? en_a : en_r;
    endfunction

    function automatic int duty_of(int i);
        return (i == 0) ? int'(duty_a) : int'(duty_r);
    endfunction

    function automatic int clampm(int i, int d);
        if (d < MN[i]) return MN[i];
        if (d > MX[i]) return MX[i];
        return d;
    endfunction

    function automatic int towards(int i, int cur, int tgt);
        if (ST[i] == 0) return tgt;
        if (tgt > cur) return (tgt - cur > ST[i]) ? cur + ST[i] : tgt;
        return (cur - tgt > ST[i]) ? cur - ST[i] : tgt;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_mode[i] <= 0;
                m_pos[i]  <= 0;
                m_app[i]  <= (MN[i] + MX[i]) / 2;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_mode[i] == 0) begin
                    if (en_of(i)) begin
                        m_mode[i] <= 1;
                        m_pos[i]  <= 0;
                        m_app[i]  <= clampm(i, duty_of(i));
                    end
                end else if (m_pos[i] == P[i] - 1) begin
                    m_pos[i] <= 0;
                    if (m_mode[i] == 1 || en_of(i)) begin
                        m_app[i]  <= towards(i, m_app[i], clampm(i, duty_of(i)));
                        m_mode[i] <= en_of(i) ? 1 : 2;
                    end else begin
                        m_mode[i] <= 0;
                    end
                end else begin
                    m_pos[i]  <= m_pos[i] + 1;
                    m_mode[i] <= en_of(i) ? 1 : 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                bit xa, xt, xp;
                xa = (m_mode[i] != 0);
                xt = xa && (m_pos[i] == 0);
                xp = xa && (m_pos[i] < m_app[i]);
                tests++;
                if ({pwm_o[i], tick_o[i], act_o[i]} !== {xp, xt, xa} || app_o[i] !== 20'(m_app[i])) begin
                    fails++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL model[%0d] t=%0t got pwm=%b tick=%b act=%b app=%0d want pwm=%b tick=%b act=%b app=%0d",
                                 i, $time, pwm_o[i], tick_o[i], act_o[i], app_o[i], xp, xt, xa, m_app[i]);
                    end
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Runs instance 0 from the current negedge until the next frame start or
    // until it goes inactive, optionally dropping/raising en at given offsets.
    task automatic run_frame(input int off_at, input int on_at,
                             output int w, output int s, output int ticked);
        w = 0;
        s = 0;
        do begin
            if (s == off_at) en_a = 1'b0;
            if (s == on_at)  en_a = 1'b1;
            if (pwm_o[0]) w++;
            s++;
            @(negedge clk);
        end while (!tick_o[0] && act_o[0] && s < 3000);
        ticked = int'(tick_o[0]);
    endtask

    // Reset instance 0 and restart it with a new duty word; returns at the
    // negedge of the first frame's tick.
    task automatic restart(input int v);
        rst    = 1'b1;
        duty_a = 20'(v);
        en_a   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- random stream for instances 1 and 2 ----------------
    initial begin
        repeat (10) @(posedge clk);
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(150) == 0) en_r = ~en_r;
            if ($urandom_range(30) == 0) duty_r = 20'($urandom_range(120));
        end
        rnd_done = 1'b1;
    end

    // ---------------- directed sequence on instance 0 ----------------
    int w, s, tk;
    int clamp_in  [6] = '{200, 0, 25, 125, 24, 126};
    int clamp_exp [6] = '{125, 25, 25, 125, 25, 125};
    int up_exp    [4] = '{77, 79, 80, 80};
    int dn_exp    [5] = '{78, 76, 74, 73, 73};

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_app", int'(app_o[0]), 75);
        chk("reset_pwm", int'(pwm_o[0]), 0);
        chk("reset_tick", int'(tick_o[0]), 0);
        chk("reset_active", int'(act_o[0]), 0);
        repeat (5) @(negedge clk);
        chk("idle_active", int'(act_o[0]), 0);

        // Start and steady frames
        en_a = 1'b1;
        @(negedge clk);
        chk("start_tick", int'(tick_o[0]), 1);
        chk("start_pwm", int'(pwm_o[0]), 1);
        chk("start_active", int'(act_o[0]), 1);
        for (int f = 0; f < 3; f++) begin
            run_frame(-1, -1, w, s, tk);
            chk("steady_width", w, 75);
            chk("steady_span", s, 1000);
        end

        // Asynchronous reset mid-pulse
        chk("pre_rst_pwm", int'(pwm_o[0]), 1);
        rst = 1'b1;
        #1;
        chk("async_pwm", int'(pwm_o[0]), 0);
        chk("async_tick", int'(tick_o[0]), 0);
        chk("async_active", int'(act_o[0]), 0);
        chk("async_app", int'(app_o[0]), 75);

        // Clamp on direct load
        for (int k = 0; k < 6; k++) begin
            restart(clamp_in[k]);
            chk("clamp_app", int'(app_o[0]), clamp_exp[k]);
            run_frame(-1, -1, w, s, tk);
            chk("clamp_width", w, clamp_exp[k]);
        end

        // Slew up then down
        restart(75);
        run_frame(-1, -1, w, s, tk);
        repeat (40) @(negedge clk);
        duty_a = 20'd80;
        chk("midframe_app", int'(app_o[0]), 75);
        run_frame(-1, -1, w, s, tk);
        for (int k = 0; k < 4; k++) begin
            chk("slew_up_app", int'(app_o[0]), up_exp[k]);
            run_frame(-1, -1, w, s, tk);
            chk("slew_up_width", w, up_exp[k]);
        end
        duty_a = 20'd73;
        chk("slew_hold_app", int'(app_o[0]), 80);
        run_frame(-1, -1, w, s, tk);
        chk("slew_hold_width", w, 80);
        for (int k = 0; k < 5; k++) begin
            chk("slew_dn_app", int'(app_o[0]), dn_exp[k]);
            run_frame(-1, -1, w, s, tk);
            chk("slew_dn_width", w, dn_exp[k]);
        end

        // Graceful stop
        run_frame(10, -1, w, s, tk);
        chk("stop_width", w, 73);
        chk("stop_span", s, 1000);
        chk("stop_tick", tk, 0);
        chk("stop_active", int'(act_o[0]), 0);
        repeat (20) @(negedge clk);
        chk("idle_pwm", int'(pwm_o[0]), 0);
        chk("idle_app", int'(app_o[0]), 73);

        // en toggle inside a frame is invisible
        en_a = 1'b1;
        @(negedge clk);
        chk("restart_tick", int'(tick_o[0]), 1);
        run_frame(10, 500, w, s, tk);
        chk("toggle_width", w, 73);
        chk("toggle_span", s, 1000);
        chk("toggle_tick", tk, 1);
        run_frame(-1, -1, w, s, tk);
        chk("after_toggle_span", s, 1000);
        chk("after_toggle_tick", tk, 1);

        // en dropped exactly at the wrap: one more frame with a duty load
        duty_a = 20'd80;
        run_frame(999, -1, w, s, tk);
        chk("wrap_stop_tick", tk, 1);
        chk("wrap_stop_app", int'(app_o[0]), 75);
        run_frame(-1, -1, w, s, tk);
        chk("last_width", w, 75);
        chk("last_span", s, 1000);
        chk("last_tick", tk, 0);
        chk("last_active", int'(act_o[0]), 0);

        for (int k = 0; k < 20000 && !rnd_done; k++) @(negedge clk);
        chk("random_done", int'(rnd_done), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
